// File: rtl/mem_arbiter_pkg.sv
// mem_pkg: shared state encoding, default sizes and grant encoding for the memory arbiter.
package mem_pkg;
    typedef enum logic [2:0] {IDLE, I_RD, D_WB, D_RD, I_RSP, D_RSP} state_t;
    localparam int MEM_LAT_DEF = 4;
    localparam int LINE_AW = 14;
    localparam int LINE_W = 64;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
    function automatic logic is_access(state_t s);
        return s inside {I_RD, D_WB, D_RD};
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request/response and memory-side strobe bundle of the arbiter.
interface mem_arbiter_if #(
    parameter int AW = mem_pkg::LINE_AW,
    parameter int LW = mem_pkg::LINE_W
) ();
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_done;
    logic [LW-1:0] i_rdata;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_dirty;
    logic [AW-1:0] d_wb_addr;
    logic [LW-1:0] d_wdata;
    logic          d_done;
    logic [LW-1:0] d_rdata;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          busy;
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_dirty, d_wb_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
    );
    modport master (
        output i_req, i_addr, d_req, d_addr, d_dirty, d_wb_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: counts 1..MEM_LAT across a fixed-latency access; start reloads to 1, idle clears.
module mem_lat_counter #(
    parameter int MEM_LAT = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          run,
    output logic [CW-1:0] cnt,
    output logic          last
);
    always_ff @(posedge clk) begin
        if (rst || !(start || run)) cnt <= '0;
        else if (start)             cnt <= CW'(1);
        else                        cnt <= cnt + 1'b1;
    end
    assign last = cnt == CW'(MEM_LAT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between I-cache refills and D-cache writeback+refill.
module mem_arbiter import mem_pkg::*; #(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int AW = LINE_AW,
    parameter int LW = LINE_W
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    state_t        state, nxt;
    logic          last_grant, grant, gnt_d;
    logic [AW-1:0] i_a, d_a, wb_a;
    logic [LW-1:0] wd, i_rd, d_rd;
    logic [3:0]    cnt;
    logic          start, run, last;
    always_comb begin
        nxt = state;
        grant = 1'b0;
        gnt_d = 1'b0;
        case (state)
            IDLE: begin
                grant = bus.i_req || bus.d_req;
                gnt_d = bus.d_req && (!bus.i_req || last_grant == GNT_I);
                nxt = !grant ? IDLE : gnt_d ? (bus.d_dirty ? D_WB : D_RD) : I_RD;
            end
            I_RD:    nxt = last ? I_RSP : I_RD;
            D_WB:    nxt = last ? D_RD : D_WB;
            D_RD:    nxt = last ? D_RSP : D_RD;
            default: nxt = IDLE;
        endcase
    end
    // counter is nonzero exactly while an access is in flight; writeback->refill restarts it
    assign start = is_access(nxt) && (cnt == '0 || last);
    assign run = cnt != '0 && !last;
    mem_lat_counter #(.MEM_LAT(MEM_LAT), .CW(4)) u_cnt (
        .clk(clk), .rst(rst), .start(start), .run(run), .cnt(cnt), .last(last)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= GNT_I;
            i_a <= '0;
            d_a <= '0;
            wb_a <= '0;
            wd <= '0;
            i_rd <= '0;
            d_rd <= '0;
        end else begin
            state <= nxt;
            if (grant) begin
                last_grant <= gnt_d ? GNT_D : GNT_I;
                i_a <= bus.i_addr;
                d_a <= bus.d_addr;
                wb_a <= bus.d_wb_addr;
                wd <= bus.d_wdata;
            end
            if (state == I_RD && last) i_rd <= bus.mem_rdata;
            if (state == D_RD && last) d_rd <= bus.mem_rdata;
        end
    end
    assign bus.mem_re = state == I_RD || state == D_RD;
    assign bus.mem_we = state == D_WB;
    assign bus.mem_addr = state == I_RD ? i_a : state == D_RD ? d_a : state == D_WB ? wb_a : '0;
    assign bus.mem_wdata = state == D_WB ? wd : '0;
    assign bus.i_done = state == I_RSP;
    assign bus.d_done = state == D_RSP;
    assign bus.i_rdata = i_rd;
    assign bus.d_rdata = d_rd;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, strobe timing, writeback sequencing and reset.
module tb_mem_arbiter;
    localparam int LAT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter_if #(.AW(14), .LW(64)) bus ();
    mem_arbiter #(.MEM_LAT(LAT), .AW(14), .LW(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    int re_run = 0;
    logic [63:0] wr_mem [16384];
    bit          wr_vld [16384];
    function automatic logic [63:0] init_line(input logic [13:0] a);
        return a == 14'h0123 ? 64'h1111_2222_3333_4444 :
               a == 14'h0155 ? 64'h5555_6666_7777_8888 :
               a == 14'h0200 ? 64'hCAFE_F00D_1234_5678 : {4{2'b00, a}};
    endfunction
    // memory model: read data is only valid on the last strobe cycle of an access
    always @(posedge clk) begin
        re_run <= bus.mem_re ? re_run + 1 : 0;
        if (bus.mem_we) begin
            wr_mem[bus.mem_addr] <= bus.mem_wdata;
            wr_vld[bus.mem_addr] <= 1'b1;
        end
    end
    always_comb begin
        bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        if (bus.mem_re && re_run == LAT - 1)
            bus.mem_rdata = wr_vld[bus.mem_addr] ? wr_mem[bus.mem_addr] : init_line(bus.mem_addr);
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        chk("excl", {63'd0, bus.mem_re & bus.mem_we}, 64'd0);
    endtask
    initial begin
        int g, nd;
        logic pi, pd, pr;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0;
        bus.d_dirty = 0; bus.d_wb_addr = 0; bus.d_wdata = 0;
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_re", bus.mem_re, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_irdata", bus.i_rdata, 0);
        chk("rst_drdata", bus.d_rdata, 0);
        chk("rst_done", {bus.i_done, bus.d_done}, 0);
        rst = 0;
        bus.i_req = 1; bus.i_addr = 14'h0123;
        tick();
        for (int k = 1; k <= LAT; k++) begin
            chk("t1_re", bus.mem_re, 1);
            chk("t1_addr", bus.mem_addr, 14'h0123);
            chk("t1_wdata", bus.mem_wdata, 0);
            chk("t1_early_done", bus.i_done, 0);
            tick();
        end
        chk("t1_done", bus.i_done, 1);
        chk("t1_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
        chk("t1_re_off", bus.mem_re, 0);
        bus.i_req = 0;
        tick();
        chk("t1_busy", bus.busy, 0);
        chk("t1_pulse", bus.i_done, 0);
        chk("t1_hold", bus.i_rdata, 64'h1111_2222_3333_4444);
        bus.d_req = 1; bus.d_dirty = 1; bus.d_wb_addr = 14'h0AAA;
        bus.d_wdata = 64'hDEAD_BEEF_0000_FFFF; bus.d_addr = 14'h0155;
        tick();
        for (int k = 1; k <= LAT; k++) begin
            chk("t2_we", {bus.mem_we, bus.mem_re}, 2'b10);
            chk("t2_wb_addr", bus.mem_addr, 14'h0AAA);
            chk("t2_wdata", bus.mem_wdata, 64'hDEAD_BEEF_0000_FFFF);
            tick();
        end
        for (int k = 1; k <= LAT; k++) begin
            chk("t2_re", {bus.mem_we, bus.mem_re}, 2'b01);
            chk("t2_rd_addr", bus.mem_addr, 14'h0155);
            chk("t2_rd_wdata", bus.mem_wdata, 0);
            chk("t2_early_done", bus.d_done, 0);
            tick();
        end
        chk("t2_done", bus.d_done, 1);
        chk("t2_rdata", bus.d_rdata, 64'h5555_6666_7777_8888);
        bus.d_req = 0; bus.d_dirty = 0;
        tick();
        chk("t2_busy", bus.busy, 0);
        chk("t2_memline", wr_mem[14'h0AAA], 64'hDEAD_BEEF_0000_FFFF);
        bus.i_req = 1; bus.i_addr = 14'h0AAA;
        tick();
        repeat (LAT) tick();
        chk("t2_readback", {bus.i_done, bus.i_rdata}, {1'b1, 64'hDEAD_BEEF_0000_FFFF});
        bus.i_req = 0;
        tick();
        rst = 1; tick(); rst = 0;
        bus.i_req = 1; bus.i_addr = 14'h0123;
        bus.d_req = 1; bus.d_addr = 14'h0155;
        tick();
        chk("t3_d_first", bus.mem_addr, 14'h0155);
        repeat (LAT) tick();
        chk("t3_d_done", {bus.d_done, bus.i_done}, 2'b10);
        bus.d_req = 0;
        tick();
        chk("t3_idle_gap", bus.busy, 0);
        tick();
        chk("t3_i_grant", {bus.mem_re, 50'd0, bus.mem_addr}, {1'b1, 50'd0, 14'h0123});
        repeat (LAT) tick();
        chk("t3_i_done_c11", bus.i_done, 1);
        chk("t3_i_rdata", bus.i_rdata, 64'h1111_2222_3333_4444);
        bus.i_req = 0;
        tick();
        rst = 1; tick(); rst = 0;
        bus.i_req = 1; bus.d_req = 1;
        g = 0; nd = 0; pi = 0; pd = 0; pr = 0;
        for (int c = 0; c < 6 * (LAT + 2); c++) begin
            tick();
            if (bus.mem_re && !pr) begin
                chk("t4_order", bus.mem_addr, (g % 2 == 0) ? 14'h0155 : 14'h0123);
                g++;
            end
            chk("t4_pulse", {pi & bus.i_done, pd & bus.d_done}, 0);
            nd += int'(bus.i_done) + int'(bus.d_done);
            pi = bus.i_done; pd = bus.d_done; pr = bus.mem_re;
        end
        chk("t4_grants", g, 6);
        chk("t4_dones", nd, 6);
        bus.i_req = 0; bus.d_req = 0;
        tick();
        chk("t4_busy", bus.busy, 0);
        bus.i_req = 1; bus.i_addr = 14'h0123;
        tick(); tick();
        rst = 1;
        tick();
        chk("t5_outs", {bus.busy, bus.mem_re, bus.mem_we, bus.i_done, bus.d_done}, 0);
        chk("t5_addr", bus.mem_addr, 0);
        chk("t5_irdata", bus.i_rdata, 0);
        chk("t5_drdata", bus.d_rdata, 0);
        rst = 0;
        tick();
        chk("t5_regrant", {bus.mem_re, bus.i_done, 48'd0, bus.mem_addr}, {2'b10, 48'd0, 14'h0123});
        repeat (LAT - 1) tick();
        chk("t5_full_lat", {bus.mem_re, bus.i_done}, 2'b10);
        tick();
        chk("t5_done", {bus.i_done, bus.i_rdata}, {1'b1, 64'h1111_2222_3333_4444});
        bus.i_req = 0;
        tick();
        bus.i_req = 1; bus.i_addr = 14'h0200;
        tick(); tick();
        bus.i_req = 0; bus.i_addr = 14'h3FFF;
        chk("t6_addr_c2", bus.mem_addr, 14'h0200);
        tick();
        chk("t6_addr_c3", {bus.mem_re, 49'd0, bus.mem_addr}, {1'b1, 49'd0, 14'h0200});
        tick(); tick();
        chk("t6_done", {bus.i_done, bus.i_rdata}, {1'b1, 64'hCAFE_F00D_1234_5678});
        tick();
        chk("t6_busy", bus.busy, 0);
        tick(); tick();
        chk("t6_no_regrant", {bus.busy, bus.mem_re, bus.i_done}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
